mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised load/store access unit between the multicycle datapath and the data memory.
- Accepts one load or store per handshake and generates the aligned address, byte enables and lane-shifted write data.
- Waits for the memory acknowledge, then returns sign- or zero-extended load data from a registered response port.
- Adds over the previous load-format logic: data width parameter, store path, request/response handshake, misalignment detection and a memory timeout.

Parameters:
- DATA_W, 32, datapath and memory word width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum cycles spent in WAIT_MEM before the access aborts; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_type  in  3  access type, shared encoding: word, half, halfu, byte, byteu, dword (dword legal only when DATA_W=64).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- mem_req  out  1  memory strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  address aligned to DATA_W/8.
- mem_wdata  out  DATA_W  store data replicated or shifted into the target lane.
- mem_ack  in  1  memory done; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout.

Behaviour:
- State machine: IDLE -> WAIT_MEM -> RESP -> IDLE.
- Reset:
  - Asynchronous; any state returns to IDLE immediately.
  - All outputs 0 except req_ready=1; timeout counter cleared.
  - A memory access in flight is abandoned, and a late mem_ack is ignored in IDLE.
- IDLE:
  - On req_valid && req_ready, latch type, store, byte offset (addr[log2(DATA_W/8)-1:0]) and data.
  - Drive the mem_* outputs from the latched registers next cycle; enter WAIT_MEM.
- WAIT_MEM:
  - mem_req held high and mem_* held stable until mem_ack.
  - On mem_ack: capture formatted rdata and go to RESP.
  - Counter increments each cycle; when it reaches TIMEOUT (TIMEOUT>0), drop mem_req, set rsp_err=10 and go to RESP.
  - mem_ack in the same cycle as the timeout wins: response is ok.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_data and rsp_err hold until the next RESP.
  - Return to IDLE; req_ready reasserts the following cycle.
  - Minimum latency, request to rsp_valid: 3 cycles with mem_ack in the first WAIT_MEM cycle.
- Byte enables:
  - byte: one bit at the offset.
  - half: two bits at offset[..:1]*2.
  - word: four bits at offset[..:2]*4.
  - dword: all bits.
- mem_wdata: the low byte, half or word of req_wdata is replicated across all lanes of that size.
- Load extraction:
  - Select the lane by offset, then sign-extend (byte, half, and word when DATA_W=64) or zero-extend (byteu, halfu).
  - word on DATA_W=32 passes the data through.
  - Illegal type codes: zero enables, rsp_data=0, rsp_err=00.
- Loads: mem_we=0, mem_be all ones. Stores: rsp_data=0.

Optional Feature:
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - A misaligned half/word/dword (offset not a multiple of the size) skips memory.
  - IDLE -> RESP directly: no mem_req, rsp_err=01, rsp_data=0.
- Undefined: misaligned low address bits are truncated to the natural alignment and the access proceeds; rsp_err is never 01.

Decomposition:
- Shared constants package: access-type codes (word, half, halfu, byte, byteu, dword), state encodings, rsp_err codes.
- One sub-module, mem_lane_fmt: combinational load lane select and extension, parametrised on DATA_W. It is instantiated on mem_rdata ahead of the capture register.

Test Plan:
- DATA_W=32, load byte at addr 0x1003, mem_rdata=0x80FF_1234, ack in 1st WAIT cycle -> rsp_data=0xFFFF_FF80, rsp_err=00, rsp_valid 3 cycles after the request.
- Store half at 0x2002, wdata=0x0000_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x2000, mem_we=1 held until ack.
- Load halfu at 0x0002, mem_ack withheld, TIMEOUT=16 -> mem_req drops after 16 WAIT cycles, rsp_err=10; a late ack is ignored and req_ready=1.
- DATA_W=64, load word at 0x0004, mem_rdata=0x8000_0001_0000_0000 -> rsp_data=0xFFFF_FFFF_8000_0001.
- With MEM_ACCESS_MISALIGN_TRAP_EN, load word at 0x0001 -> no mem_req, rsp_err=01 two cycles after the request. Without the macro -> mem_addr=0x0000, normal load.
- reset asserted in WAIT_MEM -> immediate IDLE, mem_req=0, rsp_valid=0; the next request completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store access unit: access-type codes,
// FSM state encoding, response error codes and an access-size helper.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    ACC_BYTE  = 3'b000,
    ACC_HALF  = 3'b001,
    ACC_WORD  = 3'b010,
    ACC_DWORD = 3'b011,
    ACC_BYTEU = 3'b100,
    ACC_HALFU = 3'b101
  } acc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_RESP     = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } rsp_err_e;

  // Access size in bytes; 0 marks a code that is illegal for this data width.
  function automatic logic [3:0] acc_bytes(input logic [2:0] acc_type, input int data_w);
    case (acc_type)
      ACC_BYTE, ACC_BYTEU: return 4'd1;
      ACC_HALF, ACC_HALFU: return 4'd2;
      ACC_WORD:            return 4'd4;
      ACC_DWORD:           return (data_w == 64) ? 4'd8 : 4'd0;
      default:             return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, memory and response signals of the access unit.
// master = datapath plus memory side, slave = the access unit itself.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_type;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic [1:0]            rsp_err;

  modport master (
    output req_valid, req_store, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_store, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_lane_fmt.sv
// Combinational load formatter: selects the addressed lane of a memory word
// and sign- or zero-extends it according to the access type.
module mem_lane_fmt
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            rdata,
  input  logic [2:0]                   acc_type,
  input  logic [$clog2(DATA_W/8)-1:0]  offset,
  output logic [DATA_W-1:0]            data
);
  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = '0;
    case (acc_type)
      ACC_BYTE:  data = DATA_W'(signed'(lane[7:0]));
      ACC_BYTEU: data = DATA_W'(lane[7:0]);
      ACC_HALF:  data = DATA_W'(signed'(lane[15:0]));
      ACC_HALFU: data = DATA_W'(lane[15:0]);
      // On a 32-bit datapath this is a plain pass-through.
      ACC_WORD:  data = DATA_W'(signed'(lane[31:0]));
      ACC_DWORD: data = (DATA_W == 64) ? lane : '0;
      default:   data = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: latches one request, drives an aligned memory access
// and returns a registered response. Optional macro: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e state_reg, state_next;

  logic                 store_reg;
  logic [2:0]           type_reg;
  logic [OFF_W-1:0]     off_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [BE_W-1:0]      be_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DATA_W-1:0]    rsp_data_reg;
  rsp_err_e             rsp_err_reg;

  logic [3:0]           req_size;
  logic                 req_legal;
  logic [OFF_W-1:0]     req_off;
  logic [OFF_W-1:0]     size_m1;
  logic [OFF_W-1:0]     off_aligned;
  logic [BE_W-1:0]      be_store;
  logic [BE_W-1:0]      be_next;
  logic [BE_W-1:0][7:0] wdata_lanes;
  logic                 accept;
  logic                 trap_req;
  logic                 timeout_hit;
  logic [DATA_W-1:0]    fmt_data;

  assign req_size    = acc_bytes(bus.req_type, DATA_W);
  assign req_legal   = (req_size != 4'd0);
  assign req_off     = bus.req_addr[OFF_W-1:0];
  assign size_m1     = req_legal ? OFF_W'(req_size - 4'd1) : '0;
  // Low offset bits below the access size are dropped: natural alignment.
  assign off_aligned = req_off & ~size_m1;
  assign be_store    = req_legal ? (BE_W'((16'd1 << req_size) - 16'd1) << off_aligned) : '0;
  assign be_next     = !req_legal ? '0 : (bus.req_store ? be_store : '1);

  // Each byte lane takes the matching byte of the replicated low data unit.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign wdata_lanes[gi] =
      (req_size == 4'd1) ? bus.req_wdata[7:0] :
      (req_size == 4'd2) ? bus.req_wdata[8*(gi%2) +: 8] :
      (req_size == 4'd4) ? bus.req_wdata[8*(gi%4) +: 8] :
      (req_size == 4'd8) ? bus.req_wdata[8*gi +: 8] : 8'h00;
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap_req = ((req_off & size_m1) != '0);
`else
  assign trap_req = 1'b0;
`endif

  assign accept      = bus.req_valid && (state_reg == ST_IDLE);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

  mem_lane_fmt #(.DATA_W(DATA_W)) u_lane_fmt (
    .rdata    (bus.mem_rdata),
    .acc_type (type_reg),
    .offset   (off_reg),
    .data     (fmt_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (accept) state_next = trap_req ? ST_RESP : ST_WAIT_MEM;
      ST_WAIT_MEM: if (bus.mem_ack || timeout_hit) state_next = ST_RESP;
      ST_RESP:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_reg == ST_IDLE);
    bus.mem_req   = (state_reg == ST_WAIT_MEM);
    bus.mem_we    = (state_reg == ST_WAIT_MEM) && store_reg;
    bus.mem_be    = (state_reg == ST_WAIT_MEM) ? be_reg : '0;
    bus.rsp_valid = (state_reg == ST_RESP);
  end

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_reg    <= 1'b0;
      type_reg     <= '0;
      off_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      cnt_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= ERR_OK;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            store_reg <= bus.req_store;
            type_reg  <= bus.req_type;
            off_reg   <= off_aligned;
            addr_reg  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_reg <= wdata_lanes;
            be_reg    <= be_next;
            cnt_reg   <= '0;
            if (trap_req) begin
              rsp_data_reg <= '0;
              rsp_err_reg  <= ERR_MISALIGN;
            end
          end
        end
        ST_WAIT_MEM: begin
          cnt_reg <= cnt_reg + 1'b1;
          // An acknowledge in the timeout cycle still completes normally.
          if (bus.mem_ack) begin
            rsp_data_reg <= store_reg ? '0 : fmt_data;
            rsp_err_reg  <= ERR_OK;
          end else if (timeout_hit) begin
            rsp_data_reg <= '0;
            rsp_err_reg  <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
